wb_sram_ctrl: RTL and testbench

- Wishbone classic slave front-end for a bank of sky130_sram_2kbyte_1rw1r_32x512_8 macros (32x512, 2 KB each).
- Decodes the bank and word address and drives registered SRAM controls: writes on port 0 with byte masks from wbs_sel_i, reads on port 1.
- Waits out the macro read latency, captures the read data and returns a single-cycle ack.
- Sits between the Caravel Wishbone bus and the SRAM macros in user_project_wrapper, replacing the combinational chip-select and ready logic.

---
 rtl/wb_sram_ctrl_pkg.sv | 25 ++
 rtl/wb_sram_ctrl_if.sv | 24 ++
 rtl/wb_sram_ctrl_rd_mux.sv | 21 ++
 rtl/wb_sram_ctrl.sv | 162 ++++++++++++++++
 tb/tb_wb_sram_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_sram_ctrl_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM controller.
// The macro geometry matches sky130_sram_2kbyte_1rw1r_32x512_8.
package wb_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RDW,
    ACK
  } state_e;

  localparam int SRAM_WORDS = 512;
  localparam int SRAM_AW    = 9;
  localparam int SRAM_DW    = 32;
  localparam int BANK_BYTES = 2048;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_sram_ctrl_if.sv
// Wishbone classic slave signal bundle used between the bus and the SRAM controller.
interface wb_sram_ctrl_if;
  import wb_sram_pkg::*;

  logic               wbs_cyc_i;
  logic               wbs_stb_i;
  logic               wbs_we_i;
  logic [3:0]         wbs_sel_i;
  logic [31:0]        wbs_adr_i;
  logic [SRAM_DW-1:0] wbs_dat_i;
  logic               wbs_ack_o;
  logic [SRAM_DW-1:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wb_sram_ctrl_rd_mux.sv
// Bank selection of the SRAM port-1 read data; isolated because it sits on the
// longest path from the macro outputs into the read-data register.
module wb_sram_rd_mux
  import wb_sram_pkg::*;
#(
  parameter int NBANKS = 4,
  parameter int BW     = 2
) (
  input  logic [SRAM_DW*NBANKS-1:0] dout,
  input  logic [BW-1:0]             bank,
  output logic [SRAM_DW-1:0]        rdata
);

  always_comb begin
    rdata = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (bank == BW'(b)) rdata = dout[SRAM_DW*b +: SRAM_DW];
    end
  end

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving a bank of 1RW1R SRAM macros: writes on port 0,
// reads on port 1, all macro controls registered, single-cycle ack.
module wb_sram_ctrl
  import wb_sram_pkg::*;
#(
  parameter int          NBANKS    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] OOR_DATA  = 32'h0000_0000
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  wb_sram_ctrl_if.slave             wbs,
  output logic [NBANKS-1:0]         sram_csb0,
  output logic                      sram_web0,
  output logic [3:0]                sram_wmask0,
  output logic [SRAM_AW-1:0]        sram_addr0,
  output logic [SRAM_DW-1:0]        sram_din0,
  output logic [NBANKS-1:0]         sram_csb1,
  output logic [SRAM_AW-1:0]        sram_addr1,
  input  logic [SRAM_DW*NBANKS-1:0] sram_dout1,
  output logic                      busy_o
);

  localparam int BANK_LOG = clog2(NBANKS);
  localparam int BW       = (BANK_LOG < 1) ? 1 : BANK_LOG;
  // Base is aligned to the full window, so range check is a tag compare.
  localparam int HI       = 11 + BANK_LOG;

  state_e             state, state_nx;
  logic [BW-1:0]      bank_q;
  logic [1:0]         lat_cnt;
  logic [SRAM_DW-1:0] dat_q;
  logic [SRAM_DW-1:0] rd_word;

  logic               req;
  logic               in_range;
  logic [BW-1:0]      bank_d;
  logic [SRAM_AW-1:0] word_d;

  logic start_wr, start_rd, end_wr, end_rd;
  logic load_cnt, dec_cnt, capture, load_oor;

  assign req      = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign in_range = (wbs.wbs_adr_i[31:HI] == BASE_ADDR[31:HI]);
  assign bank_d   = wbs.wbs_adr_i[11 +: BW];
  assign word_d   = wbs.wbs_adr_i[10:2];

  wb_sram_rd_mux #(
    .NBANKS (NBANKS),
    .BW     (BW)
  ) u_rd_mux (
    .dout  (sram_dout1),
    .bank  (bank_q),
    .rdata (rd_word)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start_wr = 1'b0;
    start_rd = 1'b0;
    end_wr   = 1'b0;
    end_rd   = 1'b0;
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    capture  = 1'b0;
    load_oor = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (!in_range) begin
            load_oor = 1'b1;
            state_nx = ACK;
          end else if (wbs.wbs_we_i) begin
            start_wr = 1'b1;
            state_nx = WR;
          end else begin
            start_rd = 1'b1;
            state_nx = RD;
          end
        end
      end
      WR: begin
        // The macro captures the write at the end of this cycle regardless of abort.
        end_wr   = 1'b1;
        state_nx = wbs.wbs_cyc_i ? ACK : IDLE;
      end
      RD: begin
        end_rd = 1'b1;
        if (wbs.wbs_cyc_i) begin
          load_cnt = 1'b1;
          state_nx = RDW;
        end else begin
          state_nx = IDLE;
        end
      end
      RDW: begin
        if (!wbs.wbs_cyc_i) begin
          state_nx = IDLE;
        end else if (lat_cnt == '0) begin
          capture  = 1'b1;
          state_nx = ACK;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sram_csb0   <= '1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      sram_csb1   <= '1;
      sram_addr1  <= '0;
      bank_q      <= '0;
      lat_cnt     <= '0;
      dat_q       <= '0;
    end else begin
      if (start_wr) begin
        sram_csb0   <= ~(NBANKS'(1) << bank_d);
        sram_web0   <= 1'b0;
        sram_wmask0 <= wbs.wbs_sel_i;
        sram_addr0  <= word_d;
        sram_din0   <= wbs.wbs_dat_i;
      end else if (end_wr) begin
        sram_csb0   <= '1;
        sram_web0   <= 1'b1;
        sram_wmask0 <= '0;
      end

      if (start_rd) begin
        sram_csb1  <= ~(NBANKS'(1) << bank_d);
        sram_addr1 <= word_d;
        bank_q     <= bank_d;
      end else if (end_rd) begin
        sram_csb1 <= '1;
      end

      if (load_cnt)     lat_cnt <= 2'(RD_LAT - 1);
      else if (dec_cnt) lat_cnt <= lat_cnt - 2'd1;

      if (load_oor)     dat_q <= OOR_DATA;
      else if (capture) dat_q <= rd_word;
    end
  end

  assign wbs.wbs_ack_o = (state == ACK);
  assign wbs.wbs_dat_o = dat_q;
  assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Scoreboard bench for wb_sram_ctrl: two instances (read latency 1 and 3), each
// with a behavioural 1RW1R SRAM model per bank.
`timescale 1ns/1ps
module tb_wb_sram_ctrl;
  import wb_sram_pkg::*;

  localparam int          NB   = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] OOR  = 32'hEEEE_0BAD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  logic [1:0]  cyc_v = '0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  sel   = '0;
  logic [31:0] adr   = '0;
  logic [31:0] wdat  = '0;

  logic [1:0]    ack_v, busy_v, web0_v;
  logic [31:0]   dat_v    [2];
  logic [NB-1:0] csb0_v   [2];
  logic [NB-1:0] csb1_v   [2];
  logic [3:0]    wmask0_v [2];
  logic [8:0]    addr0_v  [2];
  logic [8:0]    addr1_v  [2];
  logic [31:0]   din0_v   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;

    wb_sram_ctrl_if wbif();

    logic [NB-1:0]    csb0, csb1;
    logic             web0, busy;
    logic [3:0]       wmask0;
    logic [8:0]       addr0, addr1;
    logic [31:0]      din0;
    logic [32*NB-1:0] dout1;
    logic [31:0]      mem  [NB][512];
    logic [31:0]      pipe [NB][LAT];

    assign wbif.wbs_cyc_i = cyc_v[g];
    assign wbif.wbs_stb_i = stb;
    assign wbif.wbs_we_i  = we;
    assign wbif.wbs_sel_i = sel;
    assign wbif.wbs_adr_i = adr;
    assign wbif.wbs_dat_i = wdat;

    wb_sram_ctrl #(
      .NBANKS    (NB),
      .BASE_ADDR (BASE),
      .RD_LAT    (LAT),
      .OOR_DATA  (OOR)
    ) dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .wbs         (wbif),
      .sram_csb0   (csb0),
      .sram_web0   (web0),
      .sram_wmask0 (wmask0),
      .sram_addr0  (addr0),
      .sram_din0   (din0),
      .sram_csb1   (csb1),
      .sram_addr1  (addr1),
      .sram_dout1  (dout1),
      .busy_o      (busy)
    );

    // Macro model: data valid LAT-1 edges after the capture edge, junk otherwise.
    always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
        if (!csb0[b] && !web0)
          for (int k = 0; k < 4; k++)
            if (wmask0[k]) mem[b][addr0][8*k +: 8] <= din0[8*k +: 8];
        pipe[b][0] <= !csb1[b] ? mem[b][addr1] : (32'hBAD0_0000 | 32'(b));
        for (int s = 1; s < LAT; s++) pipe[b][s] <= pipe[b][s-1];
      end
    end

    always_comb begin
      dout1 = '0;
      for (int b = 0; b < NB; b++) dout1[32*b +: 32] = pipe[b][LAT-1];
    end

    assign ack_v[g]    = wbif.wbs_ack_o;
    assign dat_v[g]    = wbif.wbs_dat_o;
    assign busy_v[g]   = busy;
    assign web0_v[g]   = web0;
    assign csb0_v[g]   = csb0;
    assign csb1_v[g]   = csb1;
    assign wmask0_v[g] = wmask0;
    assign addr0_v[g]  = addr0;
    assign addr1_v[g]  = addr1;
    assign din0_v[g]   = din0;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    int          dut;
    bit          rd;
    logic [31:0] data;
    int unsigned ack_cyc;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] ref_mem [2][NB][512];
  logic [31:0] exp_dat [2];
  bit          cs_seen [2];

  always @(negedge clk) begin
    sb_t e;
    for (int g = 0; g < 2; g++) begin
      chk("port_excl", 32'((csb0_v[g] != '1) && (csb1_v[g] != '1)), 32'd0);
      chk("csb_1hot", 32'(($countones(~csb0_v[g]) <= 1) && ($countones(~csb1_v[g]) <= 1)), 32'd1);
      if (csb0_v[g] != '1 || csb1_v[g] != '1) cs_seen[g] = 1'b1;
      if (ack_v[g]) begin
        if (sbq.size() == 0) begin
          chk("unexp_ack", 32'(g + 1), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("ack_dut", 32'(g), 32'(e.dut));
          chk("ack_cyc", cnt, e.ack_cyc);
          if (e.rd) chk("rd_data", dat_v[g], e.data);
        end
      end
    end
  end

  task automatic req(input int d, input bit w, input logic [31:0] a,
                     input logic [31:0] dt, input logic [3:0] s);
    bit            inr;
    int            bk, wd, lat;
    sb_t           e;
    logic [NB-1:0] cs_exp;
    inr = (a >= BASE) && (a < BASE + NB * BANK_BYTES);
    bk  = int'(a[12:11]);
    wd  = int'(a[10:2]);
    if (!inr)   lat = 1;
    else if (w) lat = 2;
    else        lat = 2 + ((d == 0) ? 1 : 3);
    if (inr && w)
      for (int k = 0; k < 4; k++)
        if (s[k]) ref_mem[d][bk][wd][8*k +: 8] = dt[8*k +: 8];
    e.dut  = d;
    e.rd   = !w;
    e.data = inr ? ref_mem[d][bk][wd] : OOR;
    @(negedge clk);
    e.ack_cyc = cnt + lat;
    sbq.push_back(e);
    if (!w) exp_dat[d] = e.data;
    cyc_v[d] = 1'b1; stb = 1'b1; we = w; adr = a; wdat = dt; sel = s;
    @(negedge clk);
    cs_exp = inr ? ~(NB'(1) << bk) : '1;
    if (inr && w) begin
      chk("wr_csb0",   32'(csb0_v[d]), 32'(cs_exp));
      chk("wr_web0",   32'(web0_v[d]), 32'd0);
      chk("wr_addr0",  32'(addr0_v[d]), 32'(wd));
      chk("wr_wmask0", 32'(wmask0_v[d]), 32'(s));
      chk("wr_din0",   din0_v[d], dt);
      chk("wr_csb1",   32'(csb1_v[d]), 32'hF);
    end else if (inr) begin
      chk("rd_csb1",  32'(csb1_v[d]), 32'(cs_exp));
      chk("rd_addr1", 32'(addr1_v[d]), 32'(wd));
      chk("rd_csb0",  32'(csb0_v[d]), 32'hF);
    end else begin
      chk("oor_csb0", 32'(csb0_v[d]), 32'hF);
      chk("oor_csb1", 32'(csb1_v[d]), 32'hF);
    end
    for (int n = 0; n < 16 && !ack_v[d]; n++) @(negedge clk);
    if (!ack_v[d]) begin
      chk("ack_timeout", 32'd0, 32'd1);
      if (sbq.size() != 0) void'(sbq.pop_front());
    end
    cyc_v[d] = 1'b0; stb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_dat[0] = '0; exp_dat[1] = '0;
    cs_seen[0] = 1'b0; cs_seen[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_csb0",   32'(csb0_v[0]), 32'hF);
    chk("rst_csb1",   32'(csb1_v[0]), 32'hF);
    chk("rst_web0",   32'(web0_v[0]), 32'd1);
    chk("rst_wmask0", 32'(wmask0_v[0]), 32'd0);
    chk("rst_addr0",  32'(addr0_v[0]), 32'd0);
    chk("rst_addr1",  32'(addr1_v[0]), 32'd0);
    chk("rst_din0",   din0_v[0], 32'd0);
    chk("rst_ack",    32'(ack_v), 32'd0);
    chk("rst_dat",    dat_v[0], 32'd0);
    chk("rst_busy",   32'(busy_v), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    req(0, 1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
    req(0, 1'b0, 32'h3000_0004, 32'h0, 4'hF);
    req(0, 1'b1, 32'h3000_1FFC, 32'h1122_3344, 4'hF);
    req(0, 1'b1, 32'h3000_1FFC, 32'hFFFF_FFFF, 4'b0101);
    req(0, 1'b0, 32'h3000_1FFC, 32'h0, 4'hF);
    chk("partial_wr", exp_dat[0], 32'h11FF_33FF);

    cs_seen[0] = 1'b0;
    req(0, 1'b0, 32'h3000_2000, 32'h0, 4'hF);
    req(0, 1'b1, 32'h2FFF_FFFC, 32'h1234_5678, 4'hF);
    chk("oor_no_cs", 32'(cs_seen[0]), 32'd0);

    req(0, 1'b1, 32'h3000_1008, 32'h5555_AAAA, 4'hF);
    // Read bank 2, then drop cyc while the controller waits for the data.
    @(negedge clk);
    cyc_v[0] = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_1008; sel = 4'hF;
    @(negedge clk);
    chk("ab_csb1", 32'(csb1_v[0]), 32'b1011);
    @(negedge clk);
    chk("ab_busy_rdw", 32'(busy_v[0]), 32'd1);
    cyc_v[0] = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("ab_busy_fall", 32'(busy_v[0]), 32'd0);
    repeat (3) @(negedge clk);
    chk("ab_dat_hold", dat_v[0], exp_dat[0]);
    req(0, 1'b1, 32'h3000_0810, 32'h0BAD_CAFE, 4'hF);
    req(0, 1'b0, 32'h3000_0810, 32'h0, 4'hF);
    req(0, 1'b0, 32'h3000_1008, 32'h0, 4'hF);

    req(0, 1'b1, 32'h3000_0004, 32'hFFFF_0000, 4'h0);
    req(0, 1'b0, 32'h3000_0004, 32'h0, 4'hF);

    // Asynchronous reset while a write sits in WR.
    @(negedge clk);
    cyc_v[0] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0C00; wdat = 32'h7777_7777; sel = 4'hF;
    @(negedge clk);
    chk("wrst_pre_csb0", 32'(csb0_v[0]), 32'b1101);
    #1 rst_n = 1'b0;
    #1;
    chk("wrst_csb0", 32'(csb0_v[0]), 32'hF);
    chk("wrst_web0", 32'(web0_v[0]), 32'd1);
    chk("wrst_ack",  32'(ack_v[0]), 32'd0);
    chk("wrst_busy", 32'(busy_v[0]), 32'd0);
    chk("wrst_dat",  dat_v[0], 32'd0);
    cyc_v[0] = 1'b0; stb = 1'b0;
    exp_dat[0] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    req(1, 1'b1, 32'h3000_0814, 32'hCAFE_F00D, 4'hF);
    req(1, 1'b0, 32'h3000_0814, 32'h0, 4'hF);
    req(1, 1'b1, 32'h3000_1814, 32'h0102_0304, 4'b1001);
    req(1, 1'b0, 32'h3000_1814, 32'h0, 4'hF);
    req(1, 1'b0, 32'h3000_2004, 32'h0, 4'hF);
    req(0, 1'b0, 32'h3000_0810, 32'h0, 4'hF);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
